hdmi_video_timing_gen: RTL
==========================

// Module: hdmi_video_timing_gen
// PURPOSE
//  Downstream consumer of the tx side of the ping-pong line FIFO.
//  Generates the HDMI raster (hsync/vsync/de) and pulls pixels from the FIFO in step with active video.
//  Aligns returned pixels to DE, substitutes a fill colour on underflow and reports errors.
//  Sits between the FIFO tx port and the HDMI transmitter.
// PARAMETERS
//  H_ACTIVE   640  active pixels per line; must be a multiple of BURST_LEN
//  H_FP       16   horizontal front porch, clocks
//  H_SYNC     96   hsync width, clocks
//  H_BP       48   horizontal back porch, clocks
//  V_ACTIVE   480  active lines
//  V_FP       10   vertical front porch, lines
//  V_SYNC     2    vsync width, lines
//  V_BP       33   vertical back porch, lines
//  BURST_LEN  80   FIFO burst size in pixels; documentation and check only
//  SYNC_POL   0    sync active level: 0 = active-low, 1 = active-high
//  FILL_PIX   24'h000000  pixel driven on underflow
// PORTS
//  tx_clk         in   1   pixel clock
//  tx_rst_n       in   1   asynchronous active-low reset
//  en             in   1   run enable
//  fifo_ready_in  in   1   FIFO has a complete burst (tx_data_ready_out)
//  fifo_rd_out    out  1   read request to FIFO (tx_read_in)
//  fifo_data_in   in   24  FIFO pixel (tx_data)
//  fifo_valid_in  in   1   FIFO pixel valid (tx_valid); 2 clk after fifo_rd_out
//  clr_err        in   1   1-clk pulse; clears sticky flags and counter
//  vid_hsync      out  1   hsync
//  vid_vsync      out  1   vsync
//  vid_de         out  1   data enable
//  vid_data       out  24  RGB888 pixel
//  frame_start    out  1   1-clk pulse, aligned with first vid_de of a frame
//  busy           out  1   state == RUN
//  underflow      out  1   sticky: DE slot with no FIFO pixel
//  underflow_cnt  out  16  saturating count of underflowed pixels
//  spurious       out  1   sticky: FIFO pixel outside a DE slot
// BEHAVIOUR
//  - Reset (async): state = IDLE, counters = 0, pipeline cleared.
//    vid_de = 0, vid_data = 0, vid_hsync = vid_vsync = ~SYNC_POL.
//    fifo_rd_out = 0, frame_start = 0, busy = 0, flags = 0, underflow_cnt = 0.
//  - FSM IDLE: counters held at 0; fifo_rd_out = 0. IDLE & en & fifo_ready_in -> RUN next clk, h = v = 0.
//  - FSM RUN: h_cnt 0..H_TOTAL-1, then wraps and increments v_cnt 0..V_TOTAL-1.
//    H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is formed the same way.
//  - RUN exit: at h = H_TOTAL-1 and v = V_TOTAL-1, if en = 0 -> IDLE. Otherwise the frame wraps.
//    Deasserting en mid-frame always completes the current frame.
//  - Raw timing, combinational from counters:
//    de_r = h < H_ACTIVE & v < V_ACTIVE
//    hs_r = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
//    vs_r = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
//  - fifo_rd_out = de_r & RUN: one contiguous H_ACTIVE-clk read per line, never broken mid-line.
//  - de/hs/vs/first-pixel pass through 2 delay regs (s1, s2); s2 aligns with fifo_valid_in.
//  - Output reg (s3):
//    vid_de = de_s2
//    vid_data = de_s2 ? (fifo_valid_in ? fifo_data_in : FILL_PIX) : 0
//    syncs driven at SYNC_POL when active.
//    Counter-to-output latency = 3 clk; fifo_rd_out-to-vid_de = 3 clk.
//  - Underflow: de_s2 & ~fifo_valid_in -> underflow = 1 and underflow_cnt += 1, saturating at 16'hFFFF.
//  - Spurious: fifo_valid_in & ~de_s2 -> pixel dropped, spurious = 1.
//  - clr_err in the same clk as a new error: the error wins, with flag = 1 and cnt = 1.
//  - Pipeline drains for 3 clk after RUN->IDLE; outputs then sit at their idle levels.
//  - The timing parameters are elaborated with an initial check that H_ACTIVE % BURST_LEN == 0.
// CONFIGURATION
//  HDMI_TEST_PATTERN_EN defined:
//   - Adds input pattern_sel (1 bit).
//   - pattern_sel = 1: fifo_rd_out forced 0 and underflow/spurious detection disabled.
//   - pattern_sel = 1: vid_data shows 8 vertical colour bars, each H_ACTIVE/8 wide, in the order
//     white, yellow, cyan, green, magenta, red, blue, black.
//   - Timing is unchanged.
//   - pattern_sel is sampled at frame start only.
//  HDMI_TEST_PATTERN_EN undefined: no pattern_sel port; the FIFO path is always used.
// TESTING
//  1 Reset, en = 1, fifo_ready_in = 1, FIFO model returns a ramp.
//    -> vid_de high for 640 clk per line and 480 lines; hsync low for 96 clk; vsync low for 2 lines;
//       the frame is 800x525 clk.
//  2 Measure fifo_rd_out rise to vid_de rise.
//    -> exactly 3 clk; vid_data equals the ramp values in order; underflow = 0 and spurious = 0.
//  3 FIFO model withholds fifo_valid_in for 5 pixels mid-line.
//    -> vid_data = FILL_PIX for those 5 slots; underflow = 1; underflow_cnt = 5; vid_de unaffected.
//  4 Inject fifo_valid_in during blanking.
//    -> spurious = 1. Then pulse clr_err -> underflow = 0, spurious = 0, underflow_cnt = 0.
//  5 Drop en at line 100.
//    -> the frame finishes to v = 524, busy falls, and fifo_rd_out stays 0 afterwards.
//    Assert tx_rst_n low mid-line -> all outputs go to their reset values immediately.
//  6 With HDMI_TEST_PATTERN_EN and pattern_sel = 1.
//    -> fifo_rd_out stays 0; bar boundaries fall at h = 80, 160, ..., 560; no error flags set.

Source files
------------

// File: rtl/hdmi_video_timing_gen.sv
// hdmi_video_timing_gen
// Raster generator sitting between the ping-pong line FIFO tx port and the
// HDMI transmitter. Produces hsync/vsync/de, requests one contiguous burst
// of pixels per active line, realigns the returned pixels to DE, substitutes
// FILL_PIX on underflow and keeps sticky error flags plus a saturating
// underflow counter.
// Optional feature: define HDMI_TEST_PATTERN_EN to add the pattern_sel input
// that replaces FIFO video with eight vertical colour bars.
module hdmi_video_timing_gen #(
   parameter int          H_ACTIVE  = 640,
   parameter int          H_FP      = 16,
   parameter int          H_SYNC    = 96,
   parameter int          H_BP      = 48,
   parameter int          V_ACTIVE  = 480,
   parameter int          V_FP      = 10,
   parameter int          V_SYNC    = 2,
   parameter int          V_BP      = 33,
   parameter int          BURST_LEN = 80,
   parameter bit          SYNC_POL  = 1'b0,
   parameter logic [23:0] FILL_PIX  = 24'h000000
) (
   input  logic        tx_clk,
   input  logic        tx_rst_n,
   input  logic        en,
   input  logic        fifo_ready_in,
   output logic        fifo_rd_out,
   input  logic [23:0] fifo_data_in,
   input  logic        fifo_valid_in,
   input  logic        clr_err,
`ifdef HDMI_TEST_PATTERN_EN
   input  logic        pattern_sel,
`endif
   output logic        vid_hsync,
   output logic        vid_vsync,
   output logic        vid_de,
   output logic [23:0] vid_data,
   output logic        frame_start,
   output logic        busy,
   output logic        underflow,
   output logic [15:0] underflow_cnt,
   output logic        spurious
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

   // Bursts from the FIFO must tile an active line exactly.
   if ((H_ACTIVE % BURST_LEN) != 0) begin : g_burst_chk
      $error("H_ACTIVE must be a multiple of BURST_LEN");
   end

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            w_run;
   logic [HW-1:0]   r_h_cnt;
   logic [VW-1:0]   r_v_cnt;
   logic            w_h_last;
   logic            w_v_last;
   logic            w_de_r;
   logic            w_hs_r;
   logic            w_vs_r;
   logic            w_first;
   logic            w_pat_cur;
   logic            r_de_s1, r_hs_s1, r_vs_s1, r_first_s1, r_pat_s1;
   logic            r_de_s2, r_hs_s2, r_vs_s2, r_first_s2, r_pat_s2;
   logic            w_uf;
   logic            w_sp;
   logic [23:0]     w_pix;

   assign w_h_last = (r_h_cnt == H_LAST);
   assign w_v_last = (r_v_cnt == V_LAST);

   // State register.
   always_ff @(posedge tx_clk or negedge tx_rst_n) begin
      if (!tx_rst_n) r_state <= S_IDLE;
      else           r_state <= w_state_nxt;
   end

   // Next state: start on a full burst, leave only at the end of a frame.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (en && fifo_ready_in)            w_state_nxt = S_RUN;
         S_RUN:  if (w_h_last && w_v_last && !en)    w_state_nxt = S_IDLE;
      endcase
   end

   // State outputs.
   always_comb begin
      w_run = (r_state == S_RUN);
      busy  = w_run;
   end

   // Raster counters; held at zero while idle so a restart begins at h = v = 0.
   always_ff @(posedge tx_clk or negedge tx_rst_n) begin
      if (!tx_rst_n) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (!w_run) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (w_h_last) begin
         r_h_cnt <= '0;
         r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
      end else begin
         r_h_cnt <= r_h_cnt + 1'b1;
      end
   end

   // Raw timing decoded straight from the counters, gated so idle is quiet.
   always_comb begin
      w_de_r  = w_run && (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
      w_hs_r  = w_run && (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
      w_vs_r  = w_run && (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
      w_first = w_run && (r_h_cnt == '0) && (r_v_cnt == '0);
   end

`ifdef HDMI_TEST_PATTERN_EN
   logic          r_pat_frame;
   logic [HW-1:0] r_hpos_s1;
   logic [HW-1:0] r_hpos_s2;
   logic [2:0]    w_bar_idx;

   localparam logic [HW-1:0] BAR_W = HW'(H_ACTIVE / 8);

   function automatic logic [23:0] f_bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    f_bar_colour = 24'hFFFFFF;
         3'd1:    f_bar_colour = 24'hFFFF00;
         3'd2:    f_bar_colour = 24'h00FFFF;
         3'd3:    f_bar_colour = 24'h00FF00;
         3'd4:    f_bar_colour = 24'hFF00FF;
         3'd5:    f_bar_colour = 24'hFF0000;
         3'd6:    f_bar_colour = 24'h0000FF;
         default: f_bar_colour = 24'h000000;
      endcase
   endfunction

   // pattern_sel takes effect only on the first counter slot of a frame.
   assign w_pat_cur = w_first ? pattern_sel : r_pat_frame;

   // Hold the per-frame pattern choice.
   always_ff @(posedge tx_clk or negedge tx_rst_n) begin
      if (!tx_rst_n) r_pat_frame <= 1'b0;
      else           r_pat_frame <= w_pat_cur;
   end

   // Horizontal position follows the timing pipeline for the bar decode.
   always_ff @(posedge tx_clk or negedge tx_rst_n) begin
      if (!tx_rst_n) begin
         r_hpos_s1 <= '0;
         r_hpos_s2 <= '0;
      end else begin
         r_hpos_s1 <= r_h_cnt;
         r_hpos_s2 <= r_hpos_s1;
      end
   end

   assign w_bar_idx = 3'(r_hpos_s2 / BAR_W);

   // Pixel select including the colour-bar source.
   always_comb begin
      w_pix = 24'h000000;
      if (r_de_s2) begin
         if (r_pat_s2)           w_pix = f_bar_colour(w_bar_idx);
         else if (fifo_valid_in) w_pix = fifo_data_in;
         else                    w_pix = FILL_PIX;
      end
   end
`else
   assign w_pat_cur = 1'b0;

   // Pixel select: FIFO data in a DE slot, fill colour when it is missing.
   always_comb begin
      w_pix = 24'h000000;
      if (r_de_s2) w_pix = fifo_valid_in ? fifo_data_in : FILL_PIX;
   end
`endif

   // One contiguous read per active line; the FIFO answers two clocks later.
   assign fifo_rd_out = w_de_r && !w_pat_cur;

   // Timing delay stages s1/s2 so s2 lines up with fifo_valid_in.
   always_ff @(posedge tx_clk or negedge tx_rst_n) begin
      if (!tx_rst_n) begin
         r_de_s1 <= 1'b0; r_hs_s1 <= 1'b0; r_vs_s1 <= 1'b0;
         r_first_s1 <= 1'b0; r_pat_s1 <= 1'b0;
         r_de_s2 <= 1'b0; r_hs_s2 <= 1'b0; r_vs_s2 <= 1'b0;
         r_first_s2 <= 1'b0; r_pat_s2 <= 1'b0;
      end else begin
         r_de_s1 <= w_de_r; r_hs_s1 <= w_hs_r; r_vs_s1 <= w_vs_r;
         r_first_s1 <= w_first; r_pat_s1 <= w_pat_cur;
         r_de_s2 <= r_de_s1; r_hs_s2 <= r_hs_s1; r_vs_s2 <= r_vs_s1;
         r_first_s2 <= r_first_s1; r_pat_s2 <= r_pat_s1;
      end
   end

   // Output register s3 with sync polarity applied.
   always_ff @(posedge tx_clk or negedge tx_rst_n) begin
      if (!tx_rst_n) begin
         vid_de      <= 1'b0;
         vid_data    <= 24'h000000;
         vid_hsync   <= ~SYNC_POL;
         vid_vsync   <= ~SYNC_POL;
         frame_start <= 1'b0;
      end else begin
         vid_de      <= r_de_s2;
         vid_data    <= w_pix;
         vid_hsync   <= r_hs_s2 ? SYNC_POL : ~SYNC_POL;
         vid_vsync   <= r_vs_s2 ? SYNC_POL : ~SYNC_POL;
         frame_start <= r_first_s2;
      end
   end

   // Error detection is suppressed while the colour-bar source is active.
   assign w_uf = r_de_s2 && !fifo_valid_in && !r_pat_s2;
   assign w_sp = fifo_valid_in && !r_de_s2 && !r_pat_s2;

   // Sticky flags and counter; a new error beats a simultaneous clear.
   always_ff @(posedge tx_clk or negedge tx_rst_n) begin
      if (!tx_rst_n) begin
         underflow     <= 1'b0;
         underflow_cnt <= 16'h0000;
         spurious      <= 1'b0;
      end else begin
         if (w_uf) begin
            underflow <= 1'b1;
            if (clr_err)                       underflow_cnt <= 16'h0001;
            else if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'h0001;
         end else if (clr_err) begin
            underflow     <= 1'b0;
            underflow_cnt <= 16'h0000;
         end
         if (w_sp)         spurious <= 1'b1;
         else if (clr_err) spurious <= 1'b0;
      end
   end

endmodule
